mdu: RTL and testbench

- Iterative-latency multiply/divide unit in the EX stage.
- Takes the same A/B operand pair as the ALU and holds a 64-bit result in the architectural HI/LO registers.
- HI/LO outputs feed the EX result mux next to the ALU's C, for mfhi/mflo.
- busy drives the hazard unit, which stalls the pipeline on any MDU-dependent instruction.

---
 rtl/mdu_if.sv | 20 ++
 rtl/mdu.sv | 133 +++++++++++++
 tb/tb_mdu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDUOp, start,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, start,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Iterative-latency multiply/divide unit. The result is computed on the launch edge and
// parked in pending registers; HI/LO are only committed once the busy window has elapsed.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_pend_hi, w_pend_hi_nxt;
  logic [31:0] r_pend_lo, w_pend_lo_nxt;
  logic        r_pend_wr, w_pend_wr_nxt;

  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic [31:0]        w_a_mag, w_b_mag, w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
  logic               w_b_zero;

  assign w_smul = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign w_umul = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign w_b_mag  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_sq     = (bus.A[31] ^ bus.B[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr     = bus.A[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_uq     = bus.A / bus.B;
  assign w_ur     = bus.A % bus.B;
  assign w_b_zero = (bus.B == 32'd0);

  // Next-state: launch/move-to in IDLE, countdown and commit in RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_wr_nxt = r_pend_wr;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          case (bus.MDUOp)
            OpMult: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_smul;
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = 32'(MULT_CYCLES);
              w_state_nxt   = StRun;
            end
            OpMultu: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_umul;
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = 32'(MULT_CYCLES);
              w_state_nxt   = StRun;
            end
            OpDiv: begin
              w_pend_hi_nxt = w_sr;
              w_pend_lo_nxt = w_sq;
              // Divide by zero still burns the full latency but commits nothing.
              w_pend_wr_nxt = !w_b_zero;
              w_cnt_nxt     = 32'(DIV_CYCLES);
              w_state_nxt   = StRun;
            end
            OpDivu: begin
              w_pend_hi_nxt = w_ur;
              w_pend_lo_nxt = w_uq;
              w_pend_wr_nxt = !w_b_zero;
              w_cnt_nxt     = 32'(DIV_CYCLES);
              w_state_nxt   = StRun;
            end
            OpMthi:  w_hi_nxt = bus.A;
            OpMtlo:  w_lo_nxt = bus.A;
            default: ;
          endcase
        end
      end
      StRun: begin
        w_cnt_nxt = r_cnt - 32'd1;
        if (r_cnt == 32'd1) begin
          w_state_nxt = StIdle;
          if (r_pend_wr) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
    end
  end

  assign bus.busy = (r_state == StRun);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes the expected HI/LO and busy length per
// operation; a monitor pops and compares each time busy falls.
module tb_mdu;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mdu_if bus ();

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: HI/LO must hold during busy; on busy falling, compare against the scoreboard.
  logic [31:0] last_hi = '0, last_lo = '0;
  logic        prev_busy = 1'b0;
  int unsigned busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        check("hold_hi", bus.HI, last_hi);
        check("hold_lo", bus.LO, last_lo);
      end else begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("busy_cycles", busy_cnt, e.cyc);
            check("result_hi", bus.HI, e.hi);
            check("result_lo", bus.LO, e.lo);
          end
        end
        busy_cnt = 0;
        last_hi  = bus.HI;
        last_lo  = bus.LO;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) check("busy_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge; issues one start strobe across the next rising edge.
  task automatic strobe(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUOp = 3'b000;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int cyc);
    exp_q.push_back('{hi: eh, lo: el, cyc: 32'(cyc)});
    strobe(op, a, b);
    wait_idle(cyc + 5);
  endtask

  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.MDUOp = 3'b000;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);

    // Products and quotients; each launch starts in the cycle busy first reads 0.
    launch(OpMult,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    launch(OpMultu, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5);
    launch(OpMultu, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);
    launch(OpDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    launch(OpDivu,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10);

    // Moves into HI/LO land on the next edge without raising busy.
    strobe(OpMthi, 32'h00001234, 32'h0);
    check("mthi_hi", bus.HI, 32'h00001234);
    check("mthi_lo", bus.LO, 32'h7FFFFFFC);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    strobe(OpMtlo, 32'h00005678, 32'h0);
    check("mtlo_lo", bus.LO, 32'h00005678);
    check("mtlo_hi", bus.HI, 32'h00001234);
    check("mtlo_busy", 32'(bus.busy), 32'd0);

    // Divide by zero runs the full latency and leaves HI/LO alone.
    launch(OpDiv,  32'd5, 32'd0, 32'h00001234, 32'h00005678, 10);
    launch(OpDivu, 32'd5, 32'd0, 32'h00001234, 32'h00005678, 10);
    launch(OpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

    // Starts issued during busy must be ignored.
    exp_q.push_back('{hi: 32'h0, lo: 32'h0000000C, cyc: 32'd5});
    strobe(OpMult, 32'd3, 32'd4);
    strobe(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    strobe(OpMtlo, 32'h0000DEAD, 32'h0);
    wait_idle(10);

    // Reset during busy cycle 3 aborts the divide.
    exp_q.push_back('{hi: 32'h0, lo: 32'h0, cyc: 32'd3});
    strobe(OpDiv, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);

    // Reset together with start: nothing launches.
    reset = 1'b1;
    strobe(OpMult, 32'd3, 32'd4);
    reset = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    repeat (8) @(negedge clk);
    check("rst_start_busy_later", 32'(bus.busy), 32'd0);
    check("rst_start_lo", bus.LO, 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
